// File: rtl/mandelbrot_pkg.sv
// ============================================================================
// Module   : mandelbrot_pkg
// Brief    : Shared widths, state encodings and view-parameter type.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mandelbrot_pkg;

    localparam int PIX_X_W = 10;
    localparam int PIX_Y_W = 9;
    localparam int ITER_W  = 6;

    typedef logic signed [15:0] q4_12_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } fsm_state_e;

    typedef enum logic [1:0] {
        SLOT_FREE  = 2'd0,
        SLOT_RUN   = 2'd1,
        SLOT_DRAIN = 2'd2
    } slot_state_e;

endpackage

`default_nettype wire

// File: rtl/mandelbrot_raster_counter.sv
// ============================================================================
// Module   : mandelbrot_raster_counter
// Brief    : x-first raster walker that parks on the last pixel of the frame.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mandelbrot_raster_counter
    import mandelbrot_pkg::*;
#(
    parameter int H_RES = 640,
    parameter int V_RES = 480
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               advance,
    output logic [PIX_X_W-1:0] x,
    output logic [PIX_Y_W-1:0] y,
    output logic               last
);

    localparam logic [PIX_X_W-1:0] X_LAST = PIX_X_W'(H_RES - 1);
    localparam logic [PIX_Y_W-1:0] Y_LAST = PIX_Y_W'(V_RES - 1);

    logic [PIX_X_W-1:0] x_q, x_d;
    logic [PIX_Y_W-1:0] y_q, y_d;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clear) begin
            x_d = '0;
            y_d = '0;
        end else if (advance && !last) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x    = x_q;
    assign y    = y_q;
    assign last = (x_q == X_LAST) && (y_q == Y_LAST);

endmodule

`default_nettype wire

// File: rtl/mandelbrot_frame_scheduler.sv
// ============================================================================
// Module   : mandelbrot_frame_scheduler
// Brief    : Dispatches raster pixels round-robin to engines, retires in order.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mandelbrot_frame_scheduler
    import mandelbrot_pkg::*;
#(
    parameter int NUM_ENGINES = 2,
    parameter int H_RES       = 640,
    parameter int V_RES       = 480
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic signed [15:0]             center_x,
    input  logic signed [15:0]             center_y,
    input  logic [7:0]                     zoom_level,
    input  logic [5:0]                     max_iter_limit,
    output logic [NUM_ENGINES*10-1:0]      eng_pixel_x,
    output logic [NUM_ENGINES*10-1:0]      eng_pixel_y,
    output logic [NUM_ENGINES-1:0]         eng_pixel_valid,
    output logic signed [15:0]             eng_center_x,
    output logic signed [15:0]             eng_center_y,
    output logic [7:0]                     eng_zoom_level,
    output logic [5:0]                     eng_max_iter,
    output logic                           eng_enable,
    input  logic [NUM_ENGINES*6-1:0]       eng_iteration_count,
    input  logic [NUM_ENGINES-1:0]         eng_result_valid,
    output logic [9:0]                     out_x,
    output logic [8:0]                     out_y,
    output logic [5:0]                     out_iter,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           busy,
    output logic                           frame_done
);

    localparam int                PTR_W    = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_ENGINES - 1);

    fsm_state_e         state_q, state_d;
    slot_state_e        slot_q [NUM_ENGINES];
    slot_state_e        slot_d [NUM_ENGINES];
    logic [PIX_X_W-1:0] px_q   [NUM_ENGINES];
    logic [PIX_X_W-1:0] px_d   [NUM_ENGINES];
    logic [PIX_Y_W-1:0] py_q   [NUM_ENGINES];
    logic [PIX_Y_W-1:0] py_d   [NUM_ENGINES];
    logic [NUM_ENGINES-1:0] pv_q, pv_d;
    logic [PTR_W-1:0]   disp_ptr_q, disp_ptr_d, ret_ptr_q, ret_ptr_d;
    q4_12_t             cx_q, cx_d, cy_q, cy_d;
    logic [7:0]         zoom_q, zoom_d;
    logic [ITER_W-1:0]  miter_q, miter_d;
    logic [PIX_X_W-1:0] out_x_q, out_x_d;
    logic [PIX_Y_W-1:0] out_y_q, out_y_d;
    logic [ITER_W-1:0]  out_iter_q, out_iter_d;
    logic               out_valid_q, out_valid_d;
    logic               enable_q, enable_d, busy_q, busy_d, done_q, done_d;

    logic [PIX_X_W-1:0] ras_x;
    logic [PIX_Y_W-1:0] ras_y;
    logic               ras_last, ras_clear;
    logic               dispatch, retire, all_free;
    logic [ITER_W-1:0]  ret_iter;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    mandelbrot_raster_counter #(
        .H_RES (H_RES),
        .V_RES (V_RES)
    ) u_raster (
        .clk     (clk),
        .rst     (rst),
        .clear   (ras_clear),
        .advance (dispatch),
        .x       (ras_x),
        .y       (ras_y),
        .last    (ras_last)
    );

    // The start cycle already dispatches pixel (0,0): the raster is parked at
    // the origin for as long as the scheduler is idle.
    assign ras_clear = (state_d == ST_IDLE);
    assign dispatch  = ((state_q == ST_RUN) || (state_q == ST_IDLE && start))
                       && (slot_q[disp_ptr_q] == SLOT_FREE);
    assign ret_iter  = eng_iteration_count[int'(ret_ptr_q)*ITER_W +: ITER_W];
    assign retire    = (slot_q[ret_ptr_q] == SLOT_RUN) && eng_result_valid[ret_ptr_q]
                       && (!out_valid_q || out_ready);

    always_comb begin
        all_free = 1'b1;
        for (int k = 0; k < NUM_ENGINES; k++) begin
            if (slot_q[k] != SLOT_FREE) all_free = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            for (int k = 0; k < NUM_ENGINES; k++) begin
                slot_q[k] <= SLOT_FREE;
                px_q[k]   <= '0;
                py_q[k]   <= '0;
            end
            pv_q        <= '0;
            disp_ptr_q  <= '0;
            ret_ptr_q   <= '0;
            cx_q        <= '0;
            cy_q        <= '0;
            zoom_q      <= '0;
            miter_q     <= '0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_iter_q  <= '0;
            out_valid_q <= 1'b0;
            enable_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            px_q        <= px_d;
            py_q        <= py_d;
            pv_q        <= pv_d;
            disp_ptr_q  <= disp_ptr_d;
            ret_ptr_q   <= ret_ptr_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            zoom_q      <= zoom_d;
            miter_q     <= miter_d;
            out_x_q     <= out_x_d;
            out_y_q     <= out_y_d;
            out_iter_q  <= out_iter_d;
            out_valid_q <= out_valid_d;
            enable_q    <= enable_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start) state_d = ras_last ? ST_FLUSH : ST_RUN;
            ST_RUN:   if (dispatch && ras_last) state_d = ST_FLUSH;
            ST_FLUSH: if (all_free && !out_valid_q) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        slot_d      = slot_q;
        px_d        = px_q;
        py_d        = py_q;
        pv_d        = pv_q;
        disp_ptr_d  = disp_ptr_q;
        ret_ptr_d   = ret_ptr_q;
        cx_d        = cx_q;
        cy_d        = cy_q;
        zoom_d      = zoom_q;
        miter_d     = miter_q;
        out_x_d     = out_x_q;
        out_y_d     = out_y_q;
        out_iter_d  = out_iter_q;
        out_valid_d = out_valid_q;

        if (state_q == ST_IDLE && start) begin
            cx_d    = center_x;
            cy_d    = center_y;
            zoom_d  = zoom_level;
            miter_d = max_iter_limit;
        end

        // An engine back in IDLE still shows its old result_valid for a cycle;
        // the slot must not be reused until that has cleared.
        for (int k = 0; k < NUM_ENGINES; k++) begin
            if (slot_q[k] == SLOT_DRAIN && !eng_result_valid[k]) slot_d[k] = SLOT_FREE;
        end

        if (dispatch) begin
            slot_d[disp_ptr_q] = SLOT_RUN;
            px_d[disp_ptr_q]   = ras_x;
            py_d[disp_ptr_q]   = ras_y;
            pv_d[disp_ptr_q]   = 1'b1;
            disp_ptr_d         = ptr_inc(disp_ptr_q);
        end

        if (out_valid_q && out_ready) out_valid_d = 1'b0;

        if (retire) begin
            slot_d[ret_ptr_q] = SLOT_DRAIN;
            pv_d[ret_ptr_q]   = 1'b0;
            out_x_d           = px_q[ret_ptr_q];
            out_y_d           = py_q[ret_ptr_q];
            out_iter_d        = ret_iter;
            out_valid_d       = 1'b1;
            ret_ptr_d         = ptr_inc(ret_ptr_q);
        end

        if (state_d == ST_IDLE) begin
            disp_ptr_d = '0;
            ret_ptr_d  = '0;
        end

        enable_d = (state_d == ST_RUN);
        busy_d   = (state_d != ST_IDLE);
        done_d   = (state_q == ST_FLUSH) && (state_d == ST_IDLE);
    end

    generate
        for (genvar k = 0; k < NUM_ENGINES; k++) begin : g_eng_flat
            assign eng_pixel_x[k*PIX_X_W +: PIX_X_W] = px_q[k];
            assign eng_pixel_y[k*PIX_X_W +: PIX_X_W] = {{(PIX_X_W-PIX_Y_W){1'b0}}, py_q[k]};
        end
    endgenerate

    assign eng_pixel_valid = pv_q;
    assign eng_center_x    = cx_q;
    assign eng_center_y    = cy_q;
    assign eng_zoom_level  = zoom_q;
    assign eng_max_iter    = miter_q;
    assign eng_enable      = enable_q;
    assign out_x           = out_x_q;
    assign out_y           = out_y_q;
    assign out_iter        = out_iter_q;
    assign out_valid       = out_valid_q;
    assign busy            = busy_q;
    assign frame_done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_mandelbrot_frame_scheduler.sv
// ============================================================================
// Module   : tb_mandelbrot_frame_scheduler
// Brief    : Directed bench on a 4x2 frame with two behavioural engines.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mandelbrot_frame_scheduler;

    localparam int NE = 2;
    localparam int HR = 4;
    localparam int VR = 2;
    localparam logic [1:0] E_IDLE = 2'd0;
    localparam logic [1:0] E_BUSY = 2'd1;
    localparam logic [1:0] E_DONE = 2'd2;

    logic                  clk = 1'b0;
    logic                  rst, start, out_ready;
    logic signed [15:0]    center_x, center_y;
    logic [7:0]            zoom_level;
    logic [5:0]            max_iter_limit;
    logic [NE*10-1:0]      eng_pixel_x, eng_pixel_y;
    logic [NE-1:0]         eng_pixel_valid;
    logic signed [15:0]    eng_center_x, eng_center_y;
    logic [7:0]            eng_zoom_level;
    logic [5:0]            eng_max_iter;
    logic                  eng_enable;
    logic [NE*6-1:0]       eng_iteration_count;
    logic [NE-1:0]         eng_result_valid;
    logic [9:0]            out_x;
    logic [8:0]            out_y;
    logic [5:0]            out_iter;
    logic                  out_valid, busy, frame_done;

    int checks   = 0;
    int failures = 0;
    int lat_mode = 0;

    always #5 clk = ~clk;

    mandelbrot_frame_scheduler #(
        .NUM_ENGINES (NE),
        .H_RES       (HR),
        .V_RES       (VR)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
        .center_x            (center_x),
        .center_y            (center_y),
        .zoom_level          (zoom_level),
        .max_iter_limit      (max_iter_limit),
        .eng_pixel_x         (eng_pixel_x),
        .eng_pixel_y         (eng_pixel_y),
        .eng_pixel_valid     (eng_pixel_valid),
        .eng_center_x        (eng_center_x),
        .eng_center_y        (eng_center_y),
        .eng_zoom_level      (eng_zoom_level),
        .eng_max_iter        (eng_max_iter),
        .eng_enable          (eng_enable),
        .eng_iteration_count (eng_iteration_count),
        .eng_result_valid    (eng_result_valid),
        .out_x               (out_x),
        .out_y               (out_y),
        .out_iter            (out_iter),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .busy                (busy),
        .frame_done          (frame_done)
    );

    // Engine model: iter = x + y after a latency; result_valid stays high one
    // cycle after the engine drops back to IDLE.
    logic [1:0] e_st  [NE];
    int         e_cnt [NE];
    logic [5:0] e_it  [NE];
    logic       e_rv  [NE];

    always @(posedge clk) begin
        for (int k = 0; k < NE; k++) begin
            if (rst) begin
                e_st[k]  <= E_IDLE;
                e_cnt[k] <= 0;
                e_it[k]  <= '0;
                e_rv[k]  <= 1'b0;
            end else begin
                case (e_st[k])
                    E_IDLE: begin
                        e_rv[k] <= 1'b0;
                        if (eng_pixel_valid[k]) begin
                            e_st[k]  <= E_BUSY;
                            e_cnt[k] <= (lat_mode == 0) ? 5 : int'($urandom_range(1, 40));
                            e_it[k]  <= 6'(eng_pixel_x[k*10 +: 10] + eng_pixel_y[k*10 +: 10]);
                        end
                    end
                    E_BUSY: begin
                        if (e_cnt[k] <= 1) begin
                            e_st[k] <= E_DONE;
                            e_rv[k] <= 1'b1;
                        end else begin
                            e_cnt[k] <= e_cnt[k] - 1;
                        end
                    end
                    default: if (!eng_pixel_valid[k]) e_st[k] <= E_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NE; k++) begin
            eng_iteration_count[k*6 +: 6] = e_it[k];
            eng_result_valid[k]           = e_rv[k];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // A slot may only be redispatched once its engine's stale valid is gone.
    logic [NE-1:0] pv_prev = '0;
    logic [NE-1:0] rv_d1   = '0;
    logic [NE-1:0] rv_d2   = '0;
    logic          stall_prev = 1'b0;

    always begin
        @(negedge clk);
        #1;
        if (stall_prev) chk("hold_valid", {31'd0, out_valid}, 32'd1);
        for (int k = 0; k < NE; k++) begin
            if (eng_pixel_valid[k] && !pv_prev[k]) chk("redispatch_after_drain", {31'd0, rv_d2[k]}, 32'd0);
        end
        stall_prev = out_valid && !out_ready && !rst;
        rv_d2      = rv_d1;
        rv_d1      = eng_result_valid;
        pv_prev    = eng_pixel_valid;
    end

    task automatic expect_beat(input int ex, input int ey, input bit rnd_ready);
        int n;
        n = 0;
        out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        while (!(out_valid && out_ready) && n < 300) begin
            @(negedge clk);
            n++;
            if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
        chk("beat_arrives", {31'd0, out_valid && out_ready}, 32'd1);
        chk("beat_x", 32'(out_x), 32'(ex));
        chk("beat_y", 32'(out_y), 32'(ey));
        chk("beat_iter", 32'(out_iter), 32'(ex + ey));
        @(negedge clk);
    endtask

    task automatic expect_frame_end();
        int n;
        n = 0;
        out_ready = 1'b1;
        while (!frame_done && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("frame_done", {31'd0, frame_done}, 32'd1);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("no_extra_beat", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("frame_done_pulse", {31'd0, frame_done}, 32'd0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        start          = 1'b0;
        out_ready      = 1'b1;
        center_x       = 16'sh0000;
        center_y       = 16'sh0200;
        zoom_level     = 8'h05;
        max_iter_limit = 6'd40;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_pixel_valid", 32'(eng_pixel_valid), 32'd0);
        chk("rst_enable", {31'd0, eng_enable}, 32'd0);
        chk("rst_center_y", 32'(eng_center_y), 32'd0);
        chk("rst_frame_done", {31'd0, frame_done}, 32'd0);

        // Frame 1: fixed latency, start timing, parameter latching, stall.
        pulse_start();
        chk("start_busy", {31'd0, busy}, 32'd1);
        chk("start_enable", {31'd0, eng_enable}, 32'd1);
        chk("start_pv0", 32'(eng_pixel_valid), 32'd1);
        chk("start_x0", 32'(eng_pixel_x[9:0]), 32'd0);
        chk("start_y0", 32'(eng_pixel_y[9:0]), 32'd0);
        chk("latched_cy", 32'(eng_center_y), 32'h0200);
        chk("latched_zoom", 32'(eng_zoom_level), 32'h05);
        chk("latched_iter", 32'(eng_max_iter), 32'd40);

        expect_beat(0, 0, 1'b0);
        expect_beat(1, 0, 1'b0);
        out_ready = 1'b0;
        center_x  = 16'sh1000;
        pulse_start();
        chk("mid_frame_cx", 32'(eng_center_x), 32'h0000);
        chk("mid_frame_busy", {31'd0, busy}, 32'd1);
        expect_beat(2, 0, 1'b0);

        out_ready = 1'b0;
        repeat (20) @(negedge clk);
        chk("stall_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_x", 32'(out_x), 32'd3);
        chk("stall_y", 32'(out_y), 32'd0);
        chk("stall_iter", 32'(out_iter), 32'd3);
        chk("stall_outstanding", 32'(eng_pixel_valid), 32'd3);
        chk("stall_cx", 32'(eng_center_x), 32'h0000);
        for (int i = 3; i < HR * VR; i++) expect_beat(i % HR, i / HR, 1'b0);
        expect_frame_end();
        chk("held_cx_after_frame", 32'(eng_center_x), 32'h0000);

        // Frame 2: random engine latency and random backpressure.
        lat_mode = 1;
        pulse_start();
        chk("frame2_cx", 32'(eng_center_x), 32'h1000);
        for (int i = 0; i < HR * VR; i++) expect_beat(i % HR, i / HR, 1'b1);
        expect_frame_end();

        // Frame 3: reset with two pixels in flight.
        lat_mode  = 0;
        out_ready = 1'b0;
        pulse_start();
        @(negedge clk);
        chk("inflight_pv", 32'(eng_pixel_valid), 32'd3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_enable", {31'd0, eng_enable}, 32'd0);
        chk("mrst_pv", 32'(eng_pixel_valid), 32'd0);
        chk("mrst_px", 32'(eng_pixel_x), 32'd0);
        chk("mrst_cx", 32'(eng_center_x), 32'd0);
        chk("mrst_out_valid", {31'd0, out_valid}, 32'd0);
        repeat (3) @(negedge clk);

        // Frame 4: clean frame after the reset.
        pulse_start();
        chk("f4_pv0", 32'(eng_pixel_valid), 32'd1);
        chk("f4_x0", 32'(eng_pixel_x[9:0]), 32'd0);
        chk("f4_cx", 32'(eng_center_x), 32'h1000);
        for (int i = 0; i < HR * VR; i++) expect_beat(i % HR, i / HR, 1'b0);
        expect_frame_end();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mandelbrot_frame_scheduler.md
# mandelbrot_frame_scheduler

- Sequences a full frame of Mandelbrot work across `NUM_ENGINES` instances of `mandelbrot_engine`.
- Walks the raster, dispatches one pixel coordinate per free engine, and retires results strictly in raster order onto a valid/ready pixel stream.
- Latches view parameters at frame start so mid-frame host writes cannot tear a frame.
- Sits between the parameter bus/host control and the framebuffer writer.

## Interface
Parameters:
- `NUM_ENGINES`, 2: engine count, 1–8.
- `H_RES`, 640: pixels per line.
- `V_RES`, 480: lines per frame.

Ports:
- `clk` input 1: sole clock.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: frame start request; accepted only in IDLE.
- `center_x`, `center_y` input 16 signed: view centre, Q4.12.
- `zoom_level` input 8: zoom code.
- `max_iter_limit` input 6: iteration cap.
- `eng_pixel_x` output `NUM_ENGINES*10`: per-engine x; slice k belongs to engine k.
- `eng_pixel_y` output `NUM_ENGINES*10`: per-engine y.
- `eng_pixel_valid` output `NUM_ENGINES`: per-engine request, held until the result is captured.
- `eng_center_x`, `eng_center_y` output 16 signed: latched frame parameters, broadcast to all engines.
- `eng_zoom_level` output 8: latched, broadcast.
- `eng_max_iter` output 6: latched, broadcast.
- `eng_enable` output 1: high while RUN.
- `eng_iteration_count` input `NUM_ENGINES*6`: per-engine result.
- `eng_result_valid` input `NUM_ENGINES`: per-engine result ready; registered; stays high while the engine sits in DONE.
- `out_x` output 10, `out_y` output 9 (sized for 480 lines), `out_iter` output 6: retired pixel.
- `out_valid` output 1, `out_ready` input 1: output handshake.
- `busy` output 1: frame in progress.
- `frame_done` output 1: one-cycle pulse after the last pixel is retired.

## Operation
- Top FSM has three states: IDLE, RUN, FLUSH.
  - IDLE → RUN on `start`. In the same cycle, latch the four view parameters and set the raster to (0,0).
  - RUN → FLUSH when the last pixel (`H_RES-1`, `V_RES-1`) has been dispatched.
  - FLUSH → IDLE when every slot is FREE and `out_valid` is low (last beat accepted). `frame_done` pulses on that transition.
- Each engine slot k runs FREE → RUN → DRAIN → FREE.
  - Dispatch: if slot[`disp_ptr`] is FREE and pixels remain, write x/y into slice k, set `eng_pixel_valid[k]`, set the slot to RUN, and advance the raster and `disp_ptr` (round-robin, wraps at `NUM_ENGINES-1`). At most one dispatch per cycle.
  - Retire: if slot[`ret_ptr`] is RUN, `eng_result_valid[ret_ptr]` is high, and the output register is empty or being consumed this cycle (`out_valid && out_ready`):
    - load `out_x/out_y` from the slot's coordinate registers and `out_iter` from the engine;
    - clear `eng_pixel_valid[k]`, set the slot to DRAIN, and advance `ret_ptr`.
  - DRAIN → FREE once `eng_result_valid[k]` reads low. This guards against the stale `result_valid` the engine holds for one cycle after returning to IDLE.
- Dispatch and retire run in the same cycle on different slots. A slot freed by DRAIN in cycle t is dispatchable in cycle t+1.
- Raster increments x first. x wraps from `H_RES-1` to 0 and y increments. Counters stop after the last pixel.
- `start` while busy is ignored. Latched parameters are unaffected by host input changes until the next accepted `start`.
- Reset mid-frame:
  - all slots go to FREE, pointers and raster go to 0, and the FSM goes to IDLE;
  - all outputs go to 0 in the same cycle;
  - any in-flight engine result is discarded.
- Reset values:
  - every `eng_*` output, `out_*`, `out_valid`, `busy` and `frame_done` are 0;
  - latched parameters are 0.

## Timing
- `start` sampled at edge t → `busy` and `eng_enable` high in cycle t+1 → `eng_pixel_valid[0]` high with (0,0) in cycle t+1.
- Engine result seen high in cycle r with output free → `out_valid` high in cycle r+1, and `eng_pixel_valid[k]` low in cycle r+1.
- `out_x/out_y/out_iter` hold stable while `out_valid && !out_ready`.
- Peak throughput is one retired pixel per cycle, limited by engine latency.
- All outputs are registered; there is no combinational path from `out_ready` to `out_valid`.

## Structure
- `mandelbrot_pkg` holds:
  - the top FSM enum (IDLE/RUN/FLUSH) and slot enum (FREE/RUN/DRAIN);
  - the widths `PIX_X_W`=10, `PIX_Y_W`=9, `ITER_W`=6;
  - the Q4.12 parameter type.
- One sub-module: `mandelbrot_raster_counter` (x/y counter with advance, last-pixel flag, clear).
- Engines are instantiated by the parent, not inside this block.

## Test plan
- `H_RES`=4, `V_RES`=2, 2 engines, fixed-latency engine model (latency 5, iter=x+y) → 8 beats in order (0,0)…(3,1) with matching `out_iter`, then one `frame_done` pulse.
- Random engine latency 1–40 per pixel → output order is still pure raster and every beat's iter matches its model; no pixel is dropped or duplicated.
- `out_ready` held low 20 cycles mid-frame → `out_valid` and data stay stable, and no more than `NUM_ENGINES` engines are outstanding with `eng_pixel_valid` high.
- `center_x` changed from 0x0000 to 0x1000 mid-frame → `eng_center_x` stays 0x0000 until the next `start`; a second `start` during the frame is ignored.
- Engine holds `result_valid` one extra cycle after `pixel_valid` drops → the slot stays in DRAIN and the next pixel is not retired with the stale iter.
- `rst` asserted with 2 pixels in flight → next cycle all outputs are 0 and FSM is IDLE; a subsequent `start` produces a clean frame from (0,0).
